// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch state machine encoding (IDLE, WAIT_MEM, HOLD, WAIT_DC)
//   STRONG_NT..STRONG_T : 2-bit saturating branch counter values
//   bht_next()    : saturating counter update helper
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        HOLD     = 2'd2,
        WAIT_DC  = 2'd3
    } fetch_state_t;

    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    // Saturating increment on taken, saturating decrement on not-taken.
    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != STRONG_T) begin
                res = cnt + 2'd1;
            end
        end else begin
            if (cnt != STRONG_NT) begin
                res = cnt - 2'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// ----------------------------------------------------------------------------
// fetch_bht
// Branch history table: 2^BHT_IDX_W two-bit saturating counters indexed by
// pc[BHT_IDX_W+1:2]. Counters reset to weak not-taken.
// Ports:
//   clk_in, rst_n_in   : clock, asynchronous active-low reset
//   i_en               : global enable; updates are frozen when low
//   i_lookup_pc        : PC to predict (combinational read)
//   o_lookup_taken     : prediction (counter MSB)
//   i_upd_valid/pc/taken : committed branch outcome
// A lookup and an update to the same entry in one cycle returns the old value
// because the read is taken straight from the counter registers.
// ----------------------------------------------------------------------------
module fetch_bht
    import fetch_pkg::*;
#(
    parameter int BHT_IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        i_en,
    input  logic [31:0] i_lookup_pc,
    output logic        o_lookup_taken,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken
);

    localparam int N_ENT = 1 << BHT_IDX_W;

    logic [BHT_IDX_W-1:0] w_lookup_idx;
    logic [BHT_IDX_W-1:0] w_upd_idx;
    logic [N_ENT-1:0]     w_taken_vec;
    logic                 w_unused_pc_bits;

    assign w_lookup_idx = i_lookup_pc[BHT_IDX_W+1:2];
    assign w_upd_idx    = i_upd_pc[BHT_IDX_W+1:2];

    // Bits outside the index field do not participate in the table.
    assign w_unused_pc_bits = ^{i_lookup_pc[31:BHT_IDX_W+2], i_lookup_pc[1:0],
                                i_upd_pc[31:BHT_IDX_W+2], i_upd_pc[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < N_ENT; gi++) begin : g_ent
            logic [1:0] r_cnt;
            logic       w_hit;

            assign w_hit = i_en && i_upd_valid && (w_upd_idx == BHT_IDX_W'(gi));

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_cnt <= WEAK_NT;
                end else if (w_hit) begin
                    r_cnt <= bht_next(r_cnt, i_upd_taken);
                end
            end

            assign w_taken_vec[gi] = r_cnt[1];
        end
    endgenerate

    assign o_lookup_taken = w_taken_vec[w_lookup_idx];

endmodule

// File: rtl/ins_fetch.sv
// ----------------------------------------------------------------------------
// ins_fetch
// Instruction fetch stage upstream of the decoder. Holds the fetch PC,
// requests one 32-bit word at a time from the instruction cache, offers it to
// the decoder with its PC and a branch prediction, then waits for the
// decoder's next PC. A RoB clear redirects the fetch PC.
//
// Optional feature macro: FETCH_BHT_EN (branch history table predictor).
// Without it if_isjump is constant 0 and rob_br_* are ignored.
//
// Ports:
//   clk_in, rst_n_in      : clock, asynchronous active-low reset
//   rdy_in                : global enable; low freezes all state
//   ic_req/ic_addr        : cache request (held until response)
//   ic_valid/ic_data      : cache response
//   if_valid/if_instr/if_pc/if_isjump : instruction offered to decoder
//   dc_stall              : decoder back-pressure
//   dc_valid/dc_nextpc    : decoder accepted, next fetch PC
//   rob_clear/rob_clear_pc: mispredict flush and redirect target
//   rob_br_valid/pc/taken : committed branch outcome for predictor training
// ----------------------------------------------------------------------------
module ins_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_isjump,
    input  logic        dc_stall,
    input  logic        dc_valid,
    input  logic [31:0] dc_nextpc,
    input  logic        rob_clear,
    input  logic [31:0] rob_clear_pc,
    input  logic        rob_br_valid,
    input  logic [31:0] rob_br_pc,
    input  logic        rob_br_taken
);

    fetch_state_t r_state, r_state_next;
    logic [31:0]  r_pc, r_pc_next;
    logic         r_ic_req, r_ic_req_next;
    logic [31:0]  r_ic_addr, r_ic_addr_next;
    logic         r_if_valid, r_if_valid_next;
    logic [31:0]  r_if_instr, r_if_instr_next;
    logic [31:0]  r_if_pc, r_if_pc_next;
    logic         r_if_isjump, r_if_isjump_next;

    logic         w_pred_taken;

`ifdef FETCH_BHT_EN
    fetch_bht #(
        .BHT_IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .i_en          (rdy_in),
        .i_lookup_pc   (r_pc),
        .o_lookup_taken(w_pred_taken),
        .i_upd_valid   (rob_br_valid),
        .i_upd_pc      (rob_br_pc),
        .i_upd_taken   (rob_br_taken)
    );
`else
    logic w_unused_bht_ifc;

    assign w_pred_taken     = 1'b0;
    assign w_unused_bht_ifc = ^{rob_br_valid, rob_br_pc, rob_br_taken, (BHT_IDX_W > 0)};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_ic_req    <= 1'b0;
            r_ic_addr   <= 32'h0;
            r_if_valid  <= 1'b0;
            r_if_instr  <= 32'h0;
            r_if_pc     <= 32'h0;
            r_if_isjump <= 1'b0;
        end else begin
            r_state     <= r_state_next;
            r_pc        <= r_pc_next;
            r_ic_req    <= r_ic_req_next;
            r_ic_addr   <= r_ic_addr_next;
            r_if_valid  <= r_if_valid_next;
            r_if_instr  <= r_if_instr_next;
            r_if_pc     <= r_if_pc_next;
            r_if_isjump <= r_if_isjump_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        r_state_next     = r_state;
        r_pc_next        = r_pc;
        r_ic_req_next    = r_ic_req;
        r_ic_addr_next   = r_ic_addr;
        r_if_valid_next  = r_if_valid;
        r_if_instr_next  = r_if_instr;
        r_if_pc_next     = r_if_pc;
        r_if_isjump_next = r_if_isjump;

        if (rdy_in) begin
            if (rob_clear) begin
                // Flush wins over any response or next-PC arriving this cycle;
                // dropping ic_req tells the cache to abandon the request.
                r_pc_next       = rob_clear_pc;
                r_ic_req_next   = 1'b0;
                r_if_valid_next = 1'b0;
                r_state_next    = IDLE;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_ic_req_next  = 1'b1;
                        r_ic_addr_next = r_pc;
                        r_state_next   = WAIT_MEM;
                    end
                    WAIT_MEM: begin
                        if (ic_valid) begin
                            r_if_instr_next  = ic_data;
                            r_if_pc_next     = r_pc;
                            r_if_isjump_next = w_pred_taken;
                            r_if_valid_next  = 1'b1;
                            r_ic_req_next    = 1'b0;
                            r_state_next     = HOLD;
                        end
                    end
                    HOLD: begin
                        if (!dc_stall) begin
                            r_if_valid_next = 1'b0;
                            r_state_next    = WAIT_DC;
                        end
                    end
                    WAIT_DC: begin
                        // Issue the next request on the same edge, skipping IDLE.
                        if (dc_valid) begin
                            r_pc_next      = dc_nextpc;
                            r_ic_addr_next = dc_nextpc;
                            r_ic_req_next  = 1'b1;
                            r_state_next   = WAIT_MEM;
                        end
                    end
                    default: begin
                        r_state_next = IDLE;
                    end
                endcase
            end
        end
    end

    assign ic_req    = r_ic_req;
    assign ic_addr   = r_ic_addr;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign if_isjump = r_if_isjump;

endmodule
